// File: rtl/des_key_sched_if.sv
// rtl/des_key_sched_if.sv - key load, sub-key lookup and status signals of the DES key scheduler
interface des_key_sched_if;
  logic [63:0] key_in;
  logic        key_in_valid;
  logic        key_req_in;
  logic [3:0]  key_idx_in;
  logic [55:0] sub_key_out;
  logic        sub_key_out_valid;
  logic        check_error_out;
  logic        check_valid_out;
  logic        key_ready_out;
  logic        busy_out;

  modport master (
    output key_in, key_in_valid, key_req_in, key_idx_in,
    input  sub_key_out, sub_key_out_valid, check_error_out, check_valid_out,
           key_ready_out, busy_out
  );

  modport slave (
    input  key_in, key_in_valid, key_req_in, key_idx_in,
    output sub_key_out, sub_key_out_valid, check_error_out, check_valid_out,
           key_ready_out, busy_out
  );
endinterface

// File: rtl/des_key_sched.sv
// rtl/des_key_sched.sv - DES key parity check, PC-1 and 16-round C||D table with indexed lookup
module des_key_sched #(
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  des_key_sched_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_GEN, S_READY} state_t;

  // PC-1 selection: entry i names the DES key bit placed at C||D position i+1
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  state_t      state_q, state_d;
  logic [63:0] key_q, key_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [3:0]  round_q, round_d;
  logic [55:0] table_q [16];
  logic [55:0] table_d [16];
  logic [55:0] sub_key_q, sub_key_d;
  logic        sub_key_valid_q, sub_key_valid_d;
  logic        check_error_q, check_error_d;
  logic        check_valid_q, check_valid_d;
  logic        key_ready_q, key_ready_d;
  logic        busy_q, busy_d;

  logic        one_shift;
  logic [27:0] c_rot, d_rot;

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      r[55-i] = k[64-PC1[i]];
    end
    return r;
  endfunction

  // A byte with an even number of ones violates DES odd parity
  function automatic logic parity_err(input logic [63:0] k);
    logic e;
    e = 1'b0;
    for (int b = 0; b < 8; b++) begin
      e = e | (~^k[8*b +: 8]);
    end
    return e;
  endfunction

  assign one_shift = (round_q == 4'd0) || (round_q == 4'd1) ||
                     (round_q == 4'd8) || (round_q == 4'd15);
  assign c_rot = one_shift ? {c_q[26:0], c_q[27]} : {c_q[25:0], c_q[27:26]};
  assign d_rot = one_shift ? {d_q[26:0], d_q[27]} : {d_q[25:0], d_q[27:26]};

  always_comb begin
    state_d         = state_q;
    key_d           = key_q;
    c_d             = c_q;
    d_d             = d_q;
    round_d         = round_q;
    table_d         = table_q;
    sub_key_d       = sub_key_q;
    sub_key_valid_d = 1'b0;
    check_error_d   = check_error_q;
    check_valid_d   = 1'b0;
    key_ready_d     = key_ready_q;

    case (state_q)
      S_IDLE: begin
        if (bus.key_in_valid) begin
          key_d       = bus.key_in;
          key_ready_d = 1'b0;
          state_d     = S_CHECK;
        end
      end
      S_CHECK: begin
        check_valid_d = 1'b1;
        check_error_d = PARITY_EN && parity_err(key_q);
        {c_d, d_d}    = pc1(key_q);
        round_d       = 4'd0;
        state_d       = check_error_d ? S_IDLE : S_GEN;
      end
      S_GEN: begin
        c_d              = c_rot;
        d_d              = d_rot;
        table_d[round_q] = {c_rot, d_rot};
        round_d          = round_q + 4'd1;
        if (round_q == 4'd15) begin
          state_d     = S_READY;
          key_ready_d = 1'b1;
        end
      end
      S_READY: begin
        // The lookup reads the old table even when a new load starts this cycle
        if (bus.key_req_in) begin
          sub_key_d       = table_q[bus.key_idx_in];
          sub_key_valid_d = 1'b1;
        end
        if (bus.key_in_valid) begin
          key_d       = bus.key_in;
          key_ready_d = 1'b0;
          state_d     = S_CHECK;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_CHECK) || (state_d == S_GEN);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q         <= S_IDLE;
      key_q           <= '0;
      c_q             <= '0;
      d_q             <= '0;
      round_q         <= '0;
      sub_key_q       <= '0;
      sub_key_valid_q <= 1'b0;
      check_error_q   <= 1'b0;
      check_valid_q   <= 1'b0;
      key_ready_q     <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      key_q           <= key_d;
      c_q             <= c_d;
      d_q             <= d_d;
      round_q         <= round_d;
      sub_key_q       <= sub_key_d;
      sub_key_valid_q <= sub_key_valid_d;
      check_error_q   <= check_error_d;
      check_valid_q   <= check_valid_d;
      key_ready_q     <= key_ready_d;
      busy_q          <= busy_d;
    end
  end

  // Table contents are don't-care after reset; key_ready_out gates their use
  always_ff @(posedge clk_in) begin
    table_q <= table_d;
  end

  assign bus.sub_key_out       = sub_key_q;
  assign bus.sub_key_out_valid = sub_key_valid_q;
  assign bus.check_error_out   = check_error_q;
  assign bus.check_valid_out   = check_valid_q;
  assign bus.key_ready_out     = key_ready_q;
  assign bus.busy_out          = busy_q;

endmodule

// File: tb/tb_des_key_sched.sv
// tb/tb_des_key_sched.sv - directed vector bench for des_key_sched
module tb_des_key_sched;

  localparam logic [63:0] KEY_NOM = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_BAD = 64'h133457799BBCDFF0;

  typedef struct {
    logic [3:0]  idx;
    logic [55:0] exp;
  } sub_vec_t;

  typedef struct {
    logic [63:0] key;
    logic        err;
    logic [3:0]  idx;
    logic [55:0] exp;
  } key_vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  des_key_sched_if bus();
  des_key_sched_if bus_np();

  des_key_sched #(.PARITY_EN(1'b1)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus.slave)
  );

  des_key_sched #(.PARITY_EN(1'b0)) dut_np (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus_np.slave)
  );

  sub_vec_t sub_vecs [7];
  key_vec_t key_vecs [3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse a key at cycle T and check the status timeline through T+18
  task automatic load_key(input logic [63:0] key, input logic exp_err);
    bus.key_in       = key;
    bus.key_in_valid = 1'b1;
    step();
    bus.key_in_valid = 1'b0;
    chk("busy_t1", bus.busy_out, 1);
    chk("ready_t1", bus.key_ready_out, 0);
    step();
    chk("check_valid_t2", bus.check_valid_out, 1);
    chk("check_error_t2", bus.check_error_out, exp_err);
    chk("busy_t2", bus.busy_out, !exp_err);
    repeat (15) step();
    chk("ready_t17", bus.key_ready_out, 0);
    step();
    chk("ready_t18", bus.key_ready_out, !exp_err);
    chk("busy_t18", bus.busy_out, 0);
  endtask

  task automatic lookup(input logic [3:0] idx, input logic [55:0] exp);
    bus.key_req_in = 1'b1;
    bus.key_idx_in = idx;
    step();
    bus.key_req_in = 1'b0;
    chk("lookup_valid", bus.sub_key_out_valid, 1);
    chk($sformatf("lookup_idx%0d", idx), bus.sub_key_out, exp);
  endtask

  initial begin
    logic saw_cv;

    sub_vecs[0] = '{4'd0,  56'hE19955FAACCF1E};
    sub_vecs[1] = '{4'd1,  56'hC332ABF5599E3D};
    sub_vecs[2] = '{4'd2,  56'h0CCAAFF56678F5};
    sub_vecs[3] = '{4'd7,  56'h2ABFC339E3D559};
    sub_vecs[4] = '{4'd8,  56'h557F8663C7AAB3};
    sub_vecs[5] = '{4'd14, 56'hF866557AAB33C7};
    sub_vecs[6] = '{4'd15, 56'hF0CCAAF556678F};

    key_vecs[0] = '{64'h0101010101010101, 1'b0, 4'd5, 56'h0};
    key_vecs[1] = '{64'hFEFEFEFEFEFEFEFE, 1'b0, 4'd9, 56'hFFFFFFFFFFFFFF};
    key_vecs[2] = '{64'h0000000000000000, 1'b1, 4'd0, 56'h0};

    bus.key_in = '0;    bus.key_in_valid = 1'b0;
    bus.key_req_in = 1'b0; bus.key_idx_in = '0;
    bus_np.key_in = '0; bus_np.key_in_valid = 1'b0;
    bus_np.key_req_in = 1'b0; bus_np.key_idx_in = '0;

    rst = 1'b1;
    repeat (2) step();
    chk("rst_sub_key", bus.sub_key_out, 0);
    chk("rst_sub_valid", bus.sub_key_out_valid, 0);
    chk("rst_check_err", bus.check_error_out, 0);
    chk("rst_check_valid", bus.check_valid_out, 0);
    chk("rst_ready", bus.key_ready_out, 0);
    chk("rst_busy", bus.busy_out, 0);
    rst = 1'b0;
    step();

    // Lookup before any key is loaded is ignored
    bus.key_req_in = 1'b1;
    step();
    bus.key_req_in = 1'b0;
    chk("idle_req_valid", bus.sub_key_out_valid, 0);

    load_key(KEY_NOM, 1'b0);
    for (int i = 0; i < 7; i++) lookup(sub_vecs[i].idx, sub_vecs[i].exp);

    // Back-to-back requests, then hold
    bus.key_req_in = 1'b1;
    bus.key_idx_in = 4'd0;
    step();
    chk("b2b_valid0", bus.sub_key_out_valid, 1);
    chk("b2b_key0", bus.sub_key_out, 56'hE19955FAACCF1E);
    bus.key_idx_in = 4'd15;
    step();
    bus.key_req_in = 1'b0;
    chk("b2b_valid1", bus.sub_key_out_valid, 1);
    chk("b2b_key1", bus.sub_key_out, 56'hF0CCAAF556678F);
    step();
    chk("hold_valid", bus.sub_key_out_valid, 0);
    chk("hold_key", bus.sub_key_out, 56'hF0CCAAF556678F);

    // Lookup and load together: old table answers, bad key then fails parity
    bus.key_req_in   = 1'b1;
    bus.key_idx_in   = 4'd1;
    bus.key_in       = KEY_BAD;
    bus.key_in_valid = 1'b1;
    step();
    bus.key_req_in   = 1'b0;
    bus.key_in_valid = 1'b0;
    chk("sim_valid", bus.sub_key_out_valid, 1);
    chk("sim_key", bus.sub_key_out, 56'hC332ABF5599E3D);
    chk("sim_ready", bus.key_ready_out, 0);
    chk("sim_busy", bus.busy_out, 1);
    step();
    chk("bad_check_valid", bus.check_valid_out, 1);
    chk("bad_check_err", bus.check_error_out, 1);
    step();
    chk("bad_busy", bus.busy_out, 0);
    chk("bad_ready", bus.key_ready_out, 0);
    chk("bad_cv_pulse", bus.check_valid_out, 0);
    chk("bad_err_hold", bus.check_error_out, 1);
    bus.key_req_in = 1'b1;
    step();
    bus.key_req_in = 1'b0;
    chk("bad_req_valid", bus.sub_key_out_valid, 0);
    chk("bad_req_hold", bus.sub_key_out, 56'hC332ABF5599E3D);
    repeat (16) step();
    chk("bad_ready_late", bus.key_ready_out, 0);

    for (int i = 0; i < 3; i++) begin
      load_key(key_vecs[i].key, key_vecs[i].err);
      if (!key_vecs[i].err) lookup(key_vecs[i].idx, key_vecs[i].exp);
    end

    // Load and request during expansion are both ignored
    bus.key_in       = KEY_NOM;
    bus.key_in_valid = 1'b1;
    step();
    bus.key_in_valid = 1'b0;
    step();
    chk("ign_check_valid", bus.check_valid_out, 1);
    chk("ign_check_err", bus.check_error_out, 0);
    repeat (3) step();
    bus.key_in       = 64'h0;
    bus.key_in_valid = 1'b1;
    bus.key_req_in   = 1'b1;
    bus.key_idx_in   = 4'd3;
    step();
    bus.key_in_valid = 1'b0;
    bus.key_req_in   = 1'b0;
    chk("ign_req_valid", bus.sub_key_out_valid, 0);
    saw_cv = 1'b0;
    for (int c = 7; c <= 18; c++) begin
      if (c == 17) chk("ign_ready_t17", bus.key_ready_out, 0);
      saw_cv = saw_cv | bus.check_valid_out;
      step();
    end
    chk("ign_no_recheck", saw_cv, 0);
    chk("ign_ready_t18", bus.key_ready_out, 1);
    lookup(4'd0, 56'hE19955FAACCF1E);
    lookup(4'd15, 56'hF0CCAAF556678F);

    // Reset mid-expansion, then a fresh load rebuilds the table
    bus.key_in       = KEY_NOM;
    bus.key_in_valid = 1'b1;
    step();
    bus.key_in_valid = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_busy", bus.busy_out, 0);
    chk("mid_rst_ready", bus.key_ready_out, 0);
    chk("mid_rst_sub_key", bus.sub_key_out, 0);
    chk("mid_rst_cv", bus.check_valid_out, 0);
    repeat (12) step();
    chk("mid_rst_ready_late", bus.key_ready_out, 0);
    load_key(KEY_NOM, 1'b0);
    lookup(4'd0, 56'hE19955FAACCF1E);
    lookup(4'd15, 56'hF0CCAAF556678F);

    // Parity check disabled: bad-parity key expands (parity bits are dropped by PC-1)
    bus_np.key_in       = KEY_BAD;
    bus_np.key_in_valid = 1'b1;
    step();
    bus_np.key_in_valid = 1'b0;
    step();
    chk("np_check_valid", bus_np.check_valid_out, 1);
    chk("np_check_err", bus_np.check_error_out, 0);
    repeat (15) step();
    chk("np_ready_t17", bus_np.key_ready_out, 0);
    step();
    chk("np_ready_t18", bus_np.key_ready_out, 1);
    bus_np.key_req_in = 1'b1;
    bus_np.key_idx_in = 4'd15;
    step();
    bus_np.key_req_in = 1'b0;
    chk("np_lookup_valid", bus_np.sub_key_out_valid, 1);
    chk("np_lookup_idx15", bus_np.sub_key_out, 56'hF0CCAAF556678F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/des_key_sched.md
DES_KEY_SCHED -- requirements
Module: des_key_sched

Interface
REQ-001 Parameter PARITY_EN, default 1: 1 enables the odd-parity check on key_in; 0 forces check_error_out low.
REQ-002 clk_in  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_in  input  1  reset, synchronous, active-high.
REQ-004 key_in  input  64  DES key; DES bit n (1..64) is key_in[64-n].
REQ-005 key_in_valid  input  1  one-cycle strobe that loads key_in.
REQ-006 key_req_in  input  1  sub-key lookup request strobe.
REQ-007 key_idx_in  input  4  round index for the lookup, 0..15.
REQ-008 sub_key_out  output  56  registered C||D round value; C occupies [55:28].
REQ-009 sub_key_out_valid  output  1  one-cycle pulse marking sub_key_out valid.
REQ-010 check_error_out  output  1  parity result, registered; meaningful while check_valid_out is high.
REQ-011 check_valid_out  output  1  one-cycle pulse marking the parity result.
REQ-012 key_ready_out  output  1  high while a complete 16-entry table is held.
REQ-013 busy_out  output  1  high while a key is being checked or expanded.

Function
REQ-014 FSM states: S_IDLE, S_CHECK, S_GEN, S_READY.
REQ-015 S_IDLE or S_READY with key_in_valid=1: register key_in, clear key_ready_out, go to S_CHECK.
REQ-016 key_in_valid in S_CHECK or S_GEN: ignored; the key in progress is unaffected.
REQ-017 S_CHECK (one cycle):
- Compute parity: error if any byte of the registered key has an even number of ones.
- Pulse check_valid_out and drive check_error_out on the next cycle.
- Apply PC-1 (FIPS 46-3) to form C0/D0.
REQ-018 S_CHECK exit: go to S_IDLE on parity error (table not marked ready); otherwise go to S_GEN with round counter = 0.
REQ-019 S_GEN, one round per cycle, rounds 0..15:
- Rotate C and D left by 1 for rounds 0, 1, 8, 15 and by 2 for all other rounds.
- Write the rotated C||D to table[round].
REQ-020 S_GEN exit: after round 15, go to S_READY and set key_ready_out the following cycle.
REQ-021 Latency: key_in_valid at cycle T gives check_valid_out at T+2 and key_ready_out high from T+18.
REQ-022 busy_out is high in S_CHECK and S_GEN.
REQ-023 Lookup: key_req_in=1 in S_READY gives sub_key_out=table[key_idx_in] and a sub_key_out_valid pulse on the next cycle.
REQ-024 key_req_in outside S_READY: ignored; no valid pulse, sub_key_out holds.
REQ-025 Simultaneous key_req_in and key_in_valid in S_READY: the lookup is served from the old table and the new key load starts in the same cycle.
REQ-026 Back-to-back key_req_in: one result per cycle.
REQ-027 sub_key_out and check_error_out hold their value when their valid pulse is low.
REQ-028 The rotation totals 28 bits, so table[15] equals C0||D0.

Reset
REQ-029 rst_in=1 at a clock edge:
- State goes to S_IDLE; round counter = 0.
- All outputs go to 0: sub_key_out, sub_key_out_valid, check_error_out, check_valid_out, key_ready_out, busy_out.
REQ-030 Reset mid-S_GEN abandons the expansion; table contents are don't-care and key_ready_out stays 0 until a new key completes.

Verification
REQ-031 Nominal key:
- Stimulus: key_in=0x133457799BBCDFF1 pulsed at T.
- Response: check_valid_out=1 and check_error_out=0 at T+2; key_ready_out=1 at T+18.
REQ-032 Table contents:
- After REQ-031, request index 0 -> sub_key_out=0xE19955FAACCF1E.
- Request index 15 -> sub_key_out=0xF0CCAAF556678F.
REQ-033 Parity error:
- Stimulus: key_in=0x133457799BBCDFF0.
- Response: check_error_out=1 at T+2; FSM returns to S_IDLE; key_ready_out stays 0; later lookups produce no valid pulse.
REQ-034 Parity disabled: PARITY_EN=0 with the REQ-033 key -> check_error_out=0, expansion runs, key_ready_out=1 at T+18.
REQ-035 Ignored events:
- key_in_valid at T+5 with a different key -> no effect on the current expansion.
- key_req_in during S_GEN -> no sub_key_out_valid pulse.
REQ-036 Reset mid-expansion: rst_in=1 at T+10 -> all outputs 0 and busy_out=0 the next cycle; a fresh load of 0x133457799BBCDFF1 then reproduces the REQ-032 values.
